lcd_reader: RTL and testbench

//  Read-side companion of the 4-bit HD44780 LCD writer. Runs RW=1 read cycles: busy flag/address (RS=0) or DDRAM/CGRAM data (RS=1).

---
 rtl/lcd_reader.sv | 143 ++++++++++++++
 tb/tb_lcd_reader.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/lcd_reader.sv
// Read-side companion of the 4-bit HD44780 writer: runs RW=1 nibble-pair reads
// and assembles a byte, optionally polling the busy flag until clear or timeout.
module lcd_reader #(
    parameter int unsigned SETUP_CYC      = 2,
    parameter int unsigned E_HIGH_CYC     = 12,
    parameter int unsigned NIBBLE_GAP_CYC = 50,
    parameter int unsigned TIMEOUT_CYC    = 100000,
    parameter int unsigned CNT_W          = 17
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iStart,
    input  logic       iRS,
    input  logic       iPoll,
    input  logic [3:0] iLCD_Data,
    output logic       oLCD_Enabled,
    output logic       oLCD_RS,
    output logic       oLCD_RW,
    output logic       oActive,
    output logic       oReady,
    output logic [7:0] oData,
    output logic       oValid,
    output logic       oTimeout
);

    typedef enum logic [2:0] {
        Idle, SetupH, EHighH, Gap, SetupL, EHighL, Retry, Done
    } state_t;

    localparam logic [CNT_W-1:0] SetupLast = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EHighLast = CNT_W'(E_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] GapLast   = CNT_W'(NIBBLE_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] TimeoutLim = CNT_W'(TIMEOUT_CYC);

    state_t           state, stateNext;
    logic [CNT_W-1:0] phaseCnt, phaseCntNext;
    logic [CNT_W-1:0] toutCnt, toutCntNext;
    logic [3:0]       hiNib, hiNibNext;
    logic             rsLat, rsLatNext;
    logic             pollLat, pollLatNext;
    logic [7:0]       dataReg, dataRegNext;
    logic             toutFlag, toutFlagNext;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= Idle;
            phaseCnt <= '0;
            toutCnt  <= '0;
            hiNib    <= '0;
            rsLat    <= 1'b0;
            pollLat  <= 1'b0;
            dataReg  <= '0;
            toutFlag <= 1'b0;
        end else begin
            state    <= stateNext;
            phaseCnt <= phaseCntNext;
            toutCnt  <= toutCntNext;
            hiNib    <= hiNibNext;
            rsLat    <= rsLatNext;
            pollLat  <= pollLatNext;
            dataReg  <= dataRegNext;
            toutFlag <= toutFlagNext;
        end
    end

    always_comb begin
        stateNext    = state;
        phaseCntNext = phaseCnt + 1'b1;
        toutCntNext  = toutCnt;
        hiNibNext    = hiNib;
        rsLatNext    = rsLat;
        pollLatNext  = pollLat;
        dataRegNext  = dataReg;
        toutFlagNext = toutFlag;

        // Timeout counter runs for the whole transaction, including retries.
        if (state != Idle && toutCnt != {CNT_W{1'b1}}) begin
            toutCntNext = toutCnt + 1'b1;
        end

        unique case (state)
            Idle: begin
                phaseCntNext = '0;
                if (iStart) begin
                    stateNext   = SetupH;
                    rsLatNext   = iRS;
                    pollLatNext = iPoll & ~iRS;
                    toutCntNext = '0;
                end
            end
            SetupH: if (phaseCnt == SetupLast) begin
                stateNext    = EHighH;
                phaseCntNext = '0;
            end
            EHighH: if (phaseCnt == EHighLast) begin
                stateNext    = Gap;
                phaseCntNext = '0;
                hiNibNext    = iLCD_Data;
            end
            Gap: if (phaseCnt == GapLast) begin
                stateNext    = SetupL;
                phaseCntNext = '0;
            end
            SetupL: if (phaseCnt == SetupLast) begin
                stateNext    = EHighL;
                phaseCntNext = '0;
            end
            EHighL: if (phaseCnt == EHighLast) begin
                phaseCntNext = '0;
                if (!pollLat || !hiNib[3]) begin
                    stateNext    = Done;
                    dataRegNext  = {hiNib, iLCD_Data};
                    toutFlagNext = 1'b0;
                end else if (toutCnt >= TimeoutLim) begin
                    stateNext    = Done;
                    dataRegNext  = {hiNib, iLCD_Data};
                    toutFlagNext = 1'b1;
                end else begin
                    stateNext = Retry;
                end
            end
            Retry: if (phaseCnt == GapLast) begin
                stateNext    = SetupH;
                phaseCntNext = '0;
            end
            Done: begin
                stateNext    = Idle;
                phaseCntNext = '0;
            end
            default: stateNext = Idle;
        endcase
    end

    assign oReady       = (state == Idle);
    assign oActive      = ~oReady;
    assign oLCD_RW      = oActive;
    assign oLCD_RS      = oActive & rsLat;
    assign oLCD_Enabled = (state == EHighH) || (state == EHighL);
    assign oValid       = (state == Done);
    assign oData        = dataReg;
    assign oTimeout     = toutFlag;

endmodule

// File: tb/tb_lcd_reader.sv
// Bench for lcd_reader: cycle-by-cycle checks of panel strobes and results against
// a schedule derived from read timing arithmetic; a second instance covers poll timeout.
module tb_lcd_reader;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       iStartA = 1'b0, iStartB = 1'b0;
    logic       iRS = 1'b0, iPoll = 1'b0;
    logic [3:0] iLCD_Data = 4'h0;

    logic       eA, rsA, rwA, actA, rdyA, valA, toA;
    logic [7:0] dataA;
    logic       eB, rsB, rwB, actB, rdyB, valB, toB;
    logic [7:0] dataB;

    int passCount = 0;
    int failCount = 0;

    logic [3:0] hiN [8];
    logic [3:0] loN [8];
    logic [7:0] expDataA = 8'h00, expDataB = 8'h00;
    logic       expToA = 1'b0, expToB = 1'b0;

    lcd_reader dutA (
        .Clock(Clock), .Reset(Reset), .iStart(iStartA), .iRS(iRS), .iPoll(iPoll),
        .iLCD_Data(iLCD_Data), .oLCD_Enabled(eA), .oLCD_RS(rsA), .oLCD_RW(rwA),
        .oActive(actA), .oReady(rdyA), .oData(dataA), .oValid(valA), .oTimeout(toA)
    );

    lcd_reader #(.TIMEOUT_CYC(300)) dutB (
        .Clock(Clock), .Reset(Reset), .iStart(iStartB), .iRS(iRS), .iPoll(iPoll),
        .iLCD_Data(iLCD_Data), .oLCD_Enabled(eB), .oLCD_RS(rsB), .oLCD_RW(rwB),
        .oActive(actB), .oReady(rdyB), .oData(dataB), .oValid(valB), .oTimeout(toB)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One read transaction; called mid idle cycle, acceptance is the next rising edge.
    task automatic runTxn(input bit useB, input bit rs, input bit poll, input bit hold);
        int lim, n, dCyc, it, u;
        bit to, expE, busy;
        lim = useB ? 300 : 100000;
        n = 0;
        to = 0;
        for (int i = 0; i < 8; i++) begin
            // Counter value seen on the last E-high cycle of read i (cycle 78+128i).
            if (!(poll && !rs) || !hiN[i][3]) begin n = i + 1; to = 0; break; end
            if (77 + 128 * i >= lim) begin n = i + 1; to = 1; break; end
        end
        if (n == 0) begin
            chk("model_iterations", 0, 1);
            return;
        end
        dCyc = 79 + 128 * (n - 1);
        iRS = rs;
        iPoll = poll;
        if (useB) iStartB = 1'b1; else iStartA = 1'b1;
        for (int t = 1; t <= dCyc + 1; t++) begin
            @(posedge Clock);
            #1;
            if (!hold) begin iStartA = 1'b0; iStartB = 1'b0; end
            iRS = 1'($urandom);
            iPoll = 1'($urandom);
            it = (t - 1) / 128;
            u = t - 128 * it;
            if (t < dCyc && u >= 3 && u <= 14) iLCD_Data = hiN[it];
            else if (t < dCyc && u >= 67 && u <= 78) iLCD_Data = loN[it];
            else iLCD_Data = 4'($urandom);
            if (t == dCyc) begin
                if (useB) begin expDataB = {hiN[n-1], loN[n-1]}; expToB = to; end
                else begin expDataA = {hiN[n-1], loN[n-1]}; expToA = to; end
            end
            @(negedge Clock);
            expE = (t < dCyc) && ((u >= 3 && u <= 14) || (u >= 67 && u <= 78));
            busy = (t <= dCyc);
            chk("E",      useB ? eB : eA,     expE);
            chk("RS",     useB ? rsB : rsA,   busy & rs);
            chk("RW",     useB ? rwB : rwA,   busy);
            chk("active", useB ? actB : actA, busy);
            chk("ready",  useB ? rdyB : rdyA, !busy);
            chk("valid",  useB ? valB : valA, t == dCyc);
            chk("data",   useB ? dataB : dataA, useB ? expDataB : expDataA);
            chk("timeout", useB ? toB : toA,  useB ? expToB : expToA);
        end
    endtask

    initial begin
        int nb;
        bit rs, poll;
        // Reset state
        #3;
        chk("rst_E", eA, 0);       chk("rst_RS", rsA, 0);    chk("rst_RW", rwA, 0);
        chk("rst_active", actA, 0); chk("rst_ready", rdyA, 1); chk("rst_valid", valA, 0);
        chk("rst_data", dataA, 8'h00); chk("rst_timeout", toA, 0);
        chk("rstB_ready", rdyB, 1); chk("rstB_data", dataB, 8'h00);
        @(negedge Clock);
        Reset = 1'b1;
        repeat (2) @(negedge Clock);

        // T1: status read, nibbles 3/5
        hiN[0] = 4'h3; loN[0] = 4'h5;
        runTxn(0, 0, 0, 0);
        chk("T1_data", dataA, 8'h35);

        // T2: data read, poll request ignored when RS=1
        hiN[0] = 4'hA; loN[0] = 4'h7;
        runTxn(0, 1, 1, 0);
        chk("T2_data", dataA, 8'hA7);

        // T3: busy poll clears on the fourth read
        for (int i = 0; i < 8; i++) begin hiN[i] = 4'h8; loN[i] = 4'($urandom); end
        hiN[3] = 4'h0; loN[3] = 4'h4;
        runTxn(0, 0, 1, 0);
        chk("T3_data", dataA, 8'h04);
        chk("T3_timeout", toA, 0);

        // T4: busy stuck, short timeout instance
        for (int i = 0; i < 8; i++) begin hiN[i] = 4'h8; loN[i] = 4'($urandom); end
        runTxn(1, 0, 1, 0);
        chk("T4_timeout", toB, 1);
        chk("T4_bf", dataB[7], 1);
        chk("T4_A_idle", rdyA, 1);

        // T6: start held high, back-to-back reads
        hiN[0] = 4'($urandom); loN[0] = 4'($urandom);
        runTxn(0, 1, 0, 1);
        hiN[0] = 4'($urandom); loN[0] = 4'($urandom);
        runTxn(0, 0, 0, 0);

        // Randomized reads, optional polling with 0..3 busy responses
        for (int k = 0; k < 6; k++) begin
            rs = 1'($urandom);
            poll = 1'($urandom);
            nb = $urandom_range(0, 3);
            for (int i = 0; i < 8; i++) begin
                hiN[i] = 4'($urandom);
                loN[i] = 4'($urandom);
                if (poll && !rs) hiN[i][3] = (i < nb);
            end
            runTxn(0, rs, poll, 0);
        end

        // T5: reset during the low-nibble strobe
        hiN[0] = 4'h9; loN[0] = 4'h6;
        iRS = 1'b1; iPoll = 1'b0; iStartA = 1'b1;
        @(posedge Clock);
        #1 iStartA = 1'b0;
        repeat (69) @(posedge Clock);
        #1;
        chk("T5_E_before", eA, 1);
        Reset = 1'b0;
        #1;
        chk("T5_E", eA, 0);       chk("T5_RW", rwA, 0);     chk("T5_active", actA, 0);
        chk("T5_ready", rdyA, 1); chk("T5_valid", valA, 0); chk("T5_data", dataA, 8'h00);
        chk("T5_RS", rsA, 0);     chk("T5_timeout", toA, 0);
        @(negedge Clock);
        Reset = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge Clock);
            chk("T5_idle_valid", valA, 0);
            chk("T5_idle_ready", rdyA, 1);
        end

        $display("%0d/%0d checks passed", passCount, passCount + failCount);
        $finish;
    end

endmodule
